// File: rtl/c3lib_ckdiv_prog.sv
// Programmable integer clock divider with glitch-free ratio changes at period boundaries.
// Optional macro C3LIB_CKDIV_INV_EN adds clk_inv, an output-polarity select latched on each wrap.
module c3lib_ckdiv_prog #(
    parameter int DIV_W   = 4,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_req,
`ifdef C3LIB_CKDIV_INV_EN
    input  logic             clk_inv,
`endif
    output logic             div_ack,
    output logic             clk_out,
    output logic             clk_en,
    output logic             busy,
    output logic             dbg_state
);

    // Handshake: div_req is a one-cycle request sampled on every edge (never
    // back-pressured; a later request overwrites a pending one). busy is high
    // while a captured ratio waits for the period boundary, and div_ack pulses
    // for exactly one cycle when that ratio becomes active.

    localparam logic [DIV_W-1:0] N_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] N_RST = (DIV_RST < 2) ? N_MIN : DIV_W'(DIV_RST);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] n_act;
    logic [DIV_W-1:0] n_nxt;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] shadow_nxt;
    logic [DIV_W-1:0] req_val;
    logic [DIV_W-1:0] half;
    logic             wrap;
    logic             ack_nxt;
    logic             out_nxt;
    logic             inv_q;

    assign req_val = (div_ratio < N_MIN) ? N_MIN : div_ratio;
    assign wrap    = (cnt == (n_act - DIV_W'(1)));
    assign half    = n_act >> 1;
    assign cnt_nxt = wrap ? '0 : cnt + DIV_W'(1);

    // clk_out is a pure register of the current count, so the period boundary
    // (cnt == n_act-1) always lands in the low phase before a new ratio applies.
    assign out_nxt = (cnt < half) ^ inv_q;

`ifdef C3LIB_CKDIV_INV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (wrap) begin
            inv_q <= clk_inv;
        end
    end
`else
    assign inv_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        n_nxt      = n_act;
        ack_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (div_req) begin
                    shadow_nxt = req_val;
                    state_nxt  = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    // A request landing on the wrap edge beats the older shadow.
                    n_nxt      = div_req ? req_val : shadow;
                    shadow_nxt = n_nxt;
                    ack_nxt    = 1'b1;
                    state_nxt  = IDLE;
                end else if (div_req) begin
                    shadow_nxt = req_val;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            n_act   <= N_RST;
            shadow  <= N_RST;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
            div_ack <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            n_act   <= n_nxt;
            shadow  <= shadow_nxt;
            clk_out <= out_nxt;
            clk_en  <= out_nxt & ~clk_out;
            div_ack <= ack_nxt;
        end
    end

    assign busy      = (state == PEND);
    assign dbg_state = state;

endmodule

// File: tb/tb_c3lib_ckdiv_prog.sv
// Directed self-checking bench for c3lib_ckdiv_prog (DIV_W=4, DIV_RST=2).
// Build with C3LIB_CKDIV_INV_EN defined to also exercise the polarity select.
module tb_c3lib_ckdiv_prog;

    logic       clk;
    logic       rst_n;
    logic [3:0] div_ratio;
    logic       div_req;
    logic       clk_inv;
    logic       div_ack;
    logic       clk_out;
    logic       clk_en;
    logic       busy;
    logic       dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    c3lib_ckdiv_prog #(.DIV_W(4), .DIV_RST(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_ratio (div_ratio),
        .div_req   (div_req),
`ifdef C3LIB_CKDIV_INV_EN
        .clk_inv   (clk_inv),
`endif
        .div_ack   (div_ack),
        .clk_out   (clk_out),
        .clk_en    (clk_en),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Expected {clk_out, clk_en, div_ack} j cycles after the ack cycle for ratio n.
    function automatic logic [2:0] exp_vec(input int n, input int j);
        int ph;
        ph = j % n;
        return {(ph < n / 2) ? 1'b1 : 1'b0, (ph == 0) ? 1'b1 : 1'b0, 1'b0};
    endfunction

    task automatic do_reset;
        @(negedge clk);
        div_req   = 1'b0;
        div_ratio = 4'd0;
        clk_inv   = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs edges until div_ack is seen (max 20); drops div_req after the first edge.
    task automatic wait_ack(output int cycles, output logic busy_first);
        cycles     = 0;
        busy_first = 1'b0;
        do begin
            @(posedge clk);
            @(negedge clk);
            div_req = 1'b0;
            cycles++;
            if (cycles == 1) busy_first = busy;
        end while (div_ack !== 1'b1 && cycles < 20);
    endtask

    task automatic test_reset;
        logic [3:0] exp;
        rst_n     = 1'b1;
        div_req   = 1'b0;
        div_ratio = 4'd0;
        clk_inv   = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({clk_out, clk_en, div_ack, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_values: got %b expected 0000", {clk_out, clk_en, div_ack, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = {k[0], k[0], 1'b0, 1'b0};
            n_cmp++;
            if ({clk_out, clk_en, div_ack, busy} !== exp) begin
                n_err++;
                $display("FAIL reset_release_div2 k=%0d: got %b expected %b", k,
                         {clk_out, clk_en, div_ack, busy}, exp);
            end
        end
    endtask

    task automatic test_ratio5;
        int   c;
        logic b;
        do_reset();
        div_ratio = 4'd5;
        div_req   = 1'b1;
        wait_ack(c, b);
        n_cmp++;
        if (c !== 2 || b !== 1'b1) begin
            n_err++;
            $display("FAIL ratio5_ack_latency: got cycles=%0d busy=%b expected cycles=2 busy=1", c, b);
        end
        n_cmp++;
        if ({busy, clk_out} !== 2'b00) begin
            n_err++;
            $display("FAIL ratio5_ack_cycle: got busy/clk_out=%b expected 00", {busy, clk_out});
        end
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({clk_out, clk_en, div_ack} !== exp_vec(5, j)) begin
                n_err++;
                $display("FAIL ratio5_wave j=%0d: got %b expected %b", j,
                         {clk_out, clk_en, div_ack}, exp_vec(5, j));
            end
        end
    endtask

    task automatic test_last_wins;
        int   c;
        logic b;
        div_ratio = 4'd3;
        div_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_ratio = 4'd6;
        div_req   = 1'b1;
        wait_ack(c, b);
        n_cmp++;
        if (c !== 4 || b !== 1'b1) begin
            n_err++;
            $display("FAIL last_wins_ack: got cycles=%0d busy=%b expected cycles=4 busy=1", c, b);
        end
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({clk_out, clk_en, div_ack} !== exp_vec(6, j)) begin
                n_err++;
                $display("FAIL last_wins_wave j=%0d: got %b expected %b", j,
                         {clk_out, clk_en, div_ack}, exp_vec(6, j));
            end
        end
    endtask

    task automatic test_req_on_pend_wrap;
        int   c;
        logic b;
        do_reset();
        div_ratio = 4'd7;
        div_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_ratio = 4'd4;
        div_req   = 1'b1;
        wait_ack(c, b);
        n_cmp++;
        if (c !== 1) begin
            n_err++;
            $display("FAIL pend_wrap_ack: got cycles=%0d expected 1", c);
        end
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({clk_out, clk_en, div_ack} !== exp_vec(4, j)) begin
                n_err++;
                $display("FAIL pend_wrap_wave j=%0d: got %b expected %b", j,
                         {clk_out, clk_en, div_ack}, exp_vec(4, j));
            end
        end
    endtask

    task automatic test_req_on_idle_wrap;
        int   c;
        logic b;
        do_reset();
        @(posedge clk);
        @(negedge clk);
        div_ratio = 4'd3;
        div_req   = 1'b1;
        wait_ack(c, b);
        n_cmp++;
        if (c !== 3 || b !== 1'b1) begin
            n_err++;
            $display("FAIL idle_wrap_ack: got cycles=%0d busy=%b expected cycles=3 busy=1", c, b);
        end
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({clk_out, clk_en, div_ack} !== exp_vec(3, j)) begin
                n_err++;
                $display("FAIL idle_wrap_wave j=%0d: got %b expected %b", j,
                         {clk_out, clk_en, div_ack}, exp_vec(3, j));
            end
        end
    endtask

    task automatic test_clamp;
        int   c;
        logic b;
        do_reset();
        div_ratio = 4'd0;
        div_req   = 1'b1;
        wait_ack(c, b);
        n_cmp++;
        if (c !== 2) begin
            n_err++;
            $display("FAIL clamp0_ack: got cycles=%0d expected 2", c);
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({clk_out, clk_en, div_ack} !== exp_vec(2, j)) begin
                n_err++;
                $display("FAIL clamp0_wave j=%0d: got %b expected %b", j,
                         {clk_out, clk_en, div_ack}, exp_vec(2, j));
            end
        end
        div_ratio = 4'd1;
        div_req   = 1'b1;
        wait_ack(c, b);
        n_cmp++;
        if (c !== 2) begin
            n_err++;
            $display("FAIL clamp1_same_ratio_ack: got cycles=%0d expected 2", c);
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({clk_out, clk_en, div_ack} !== exp_vec(2, j)) begin
                n_err++;
                $display("FAIL clamp1_wave j=%0d: got %b expected %b", j,
                         {clk_out, clk_en, div_ack}, exp_vec(2, j));
            end
        end
    endtask

    task automatic test_reset_pend;
        int         c;
        logic       b;
        logic [3:0] exp;
        do_reset();
        div_ratio = 4'd5;
        div_req   = 1'b1;
        wait_ack(c, b);
        div_ratio = 4'd9;
        div_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_req = 1'b0;
        n_cmp++;
        if ({busy, clk_out} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_pend_pre: got busy/clk_out=%b expected 11", {busy, clk_out});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({clk_out, clk_en, div_ack, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pend_async: got %b expected 0000", {clk_out, clk_en, div_ack, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = {k[0], k[0], 1'b0, 1'b0};
            n_cmp++;
            if ({clk_out, clk_en, div_ack, busy} !== exp) begin
                n_err++;
                $display("FAIL reset_pend_after k=%0d: got %b expected %b", k,
                         {clk_out, clk_en, div_ack, busy}, exp);
            end
        end
    endtask

`ifdef C3LIB_CKDIV_INV_EN
    task automatic test_invert;
        int          c;
        logic        b;
        logic [11:0] out_tab;
        logic [11:0] en_tab;
        out_tab = 12'b110011000011;
        en_tab  = 12'b010001000001;
        do_reset();
        div_ratio = 4'd4;
        div_req   = 1'b1;
        wait_ack(c, b);
        n_cmp++;
        if (c !== 2) begin
            n_err++;
            $display("FAIL invert_ack: got cycles=%0d expected 2", c);
        end
        for (int j = 0; j < 12; j++) begin
            if (j == 2) clk_inv = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({clk_out, clk_en} !== {out_tab[j], en_tab[j]}) begin
                n_err++;
                $display("FAIL invert_wave j=%0d: got %b expected %b", j,
                         {clk_out, clk_en}, {out_tab[j], en_tab[j]});
            end
        end
        clk_inv = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ratio5();
        test_last_wins();
        test_req_on_pend_wrap();
        test_req_on_idle_wrap();
        test_clamp();
        test_reset_pend();
`ifdef C3LIB_CKDIV_INV_EN
        test_invert();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
